// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end that time-shares one sqrt unit between
// N_REQ requesters, with a watchdog that aborts a hung transaction.
module sqrt_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned OP_W    = 8,
  parameter int unsigned RES_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_vld_i,
  input  logic [N_REQ*OP_W-1:0]      req_op_i,
  output logic [N_REQ-1:0]           req_rdy_o,
  output logic [N_REQ-1:0]           rsp_vld_o,
  output logic [RES_W-1:0]           rsp_res_o,
  output logic                       rsp_err_o,
  output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
  output logic                       sqrt_enb_o,
  output logic [OP_W-1:0]            sqrt_op_o,
  input  logic                       sqrt_busy_i,
  input  logic [RES_W-1:0]           sqrt_res_i,
  output logic                       busy_o
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id;
  logic [CNT_W-1:0]   cnt;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    cand;
  logic [OP_W-1:0]    gnt_op;
  logic               grant;
  logic               wd_hit;
  logic [N_REQ-1:0]   id_oh;
  logic [ID_W-1:0]    ptr_nxt;

  // Round-robin search starting at ptr; first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!gnt_vld && req_vld_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    gnt_op = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == gnt_id) gnt_op = req_op_i[k*OP_W +: OP_W];
    end
  end

  // Handshake strobe, watchdog compare and response helpers.
  always_comb begin
    grant     = (state == IDLE) && !rst_i && !sqrt_busy_i && gnt_vld;
    req_rdy_o = grant ? (N_REQ'(1) << gnt_id) : '0;
    wd_hit    = (cnt == CNT_W'(TIMEOUT - 1));
    id_oh     = N_REQ'(1) << id;
    ptr_nxt   = (id == ID_W'(N_REQ - 1)) ? '0 : id + ID_W'(1);
  end

  // Transaction FSM with registered outputs; completion beats the watchdog.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      cnt        <= '0;
      rsp_vld_o  <= '0;
      rsp_res_o  <= '0;
      rsp_err_o  <= 1'b0;
      rsp_id_o   <= '0;
      sqrt_enb_o <= 1'b0;
      sqrt_op_o  <= '0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sqrt_op_o  <= gnt_op;
            id         <= gnt_id;
            cnt        <= '0;
            sqrt_enb_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (sqrt_busy_i) begin
            sqrt_enb_o <= 1'b0;
            cnt        <= cnt + CNT_W'(1);
            state      <= RUN;
          end else if (wd_hit) begin
            sqrt_enb_o <= 1'b0;
            rsp_vld_o  <= id_oh;
            rsp_res_o  <= '0;
            rsp_err_o  <= 1'b1;
            rsp_id_o   <= id;
            state      <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!sqrt_busy_i) begin
            rsp_vld_o <= id_oh;
            rsp_res_o <= sqrt_res_i;
            rsp_err_o <= 1'b0;
            rsp_id_o  <= id;
            state     <= RESP;
          end else if (wd_hit) begin
            rsp_vld_o <= id_oh;
            rsp_res_o <= '0;
            rsp_err_o <= 1'b1;
            rsp_id_o  <= id;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_vld_o <= '0;
          ptr       <= ptr_nxt;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          sqrt_enb_o <= 1'b0;
          rsp_vld_o  <= '0;
          busy_o     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: scoreboard bench with a behavioural sqrt unit model.
module tb_sqrt_arbiter;

  localparam int N  = 4;
  localparam int OW = 8;
  localparam int RW = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [N-1:0]      req_vld_i = '0;
  logic [N*OW-1:0]   req_op_i = '0;
  logic [N-1:0]      req_rdy_o;
  logic [N-1:0]      rsp_vld_o;
  logic [RW-1:0]     rsp_res_o;
  logic              rsp_err_o;
  logic [1:0]        rsp_id_o;
  logic              sqrt_enb_o;
  logic [OW-1:0]     sqrt_op_o;
  logic              sqrt_busy_i = 1'b0;
  logic [RW-1:0]     sqrt_res_i = '0;
  logic              busy_o;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N_REQ(N), .OP_W(OW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_vld_i(req_vld_i), .req_op_i(req_op_i), .req_rdy_o(req_rdy_o),
    .rsp_vld_o(rsp_vld_o), .rsp_res_o(rsp_res_o), .rsp_err_o(rsp_err_o),
    .rsp_id_o(rsp_id_o), .sqrt_enb_o(sqrt_enb_o), .sqrt_op_o(sqrt_op_o),
    .sqrt_busy_i(sqrt_busy_i), .sqrt_res_i(sqrt_res_i), .busy_o(busy_o)
  );

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Sqrt unit model: busy the cycle after enb, result valid only as busy falls.
  int m_lat = 2;
  bit stuck = 1'b0;
  int m_cnt = 0;
  int m_op  = 0;
  always @(posedge clk) begin
    sqrt_res_i <= RW'(~isqrt(m_op));
    if (!sqrt_busy_i) begin
      if (sqrt_enb_o && !stuck) begin
        sqrt_busy_i <= 1'b1;
        m_cnt       <= m_lat;
        m_op        <= int'(sqrt_op_o);
      end
    end else if (m_cnt == 0) begin
      sqrt_busy_i <= 1'b0;
      sqrt_res_i  <= RW'(isqrt(m_op));
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct { int id; int op; int res; int err; int enb; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int tb_ptr = 0;
  int inflight = 0;
  int enb_cnt = 0;
  int pop_req = -1;
  int n_busy_wait = 0;
  int pend_op[N][8];
  int pend_n[N] = '{default: 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int winner(input int p, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (((v >> k) & N'(1)) != 0) return k;
    end
    return -1;
  endfunction

  function automatic int pend_total();
    int t = 0;
    for (int k = 0; k < N; k++) t += pend_n[k];
    return t;
  endfunction

  task automatic push(input int k, input int op);
    pend_op[k][pend_n[k]] = op;
    pend_n[k]++;
  endtask

  // One clock: drive inputs after the edge, check and score at the falling edge.
  task automatic tick();
    int w;
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs;
    exp_t e;
    @(posedge clk);
    #1;
    if (pop_req >= 0) begin
      for (int i = 0; i < 7; i++) pend_op[pop_req][i] = pend_op[pop_req][i+1];
      pend_n[pop_req]--;
      pop_req = -1;
    end
    for (int k = 0; k < N; k++) begin
      req_vld_i[k] = (pend_n[k] > 0);
      req_op_i[k*OW +: OW] = (pend_n[k] > 0) ? OW'(pend_op[k][0]) : '0;
    end
    @(negedge clk);
    if (!rst_i) begin
      w = winner(tb_ptr, req_vld_i);
      exp_rdy = (inflight == 0 && !sqrt_busy_i && w >= 0) ? N'(1 << w) : '0;
      chk("rdy", 32'(req_rdy_o), 32'(exp_rdy));
      chk("busy_o", 32'(busy_o), 32'(inflight));
      if (inflight == 0 && sqrt_busy_i && req_vld_i != 0) n_busy_wait++;
      if (sqrt_enb_o) enb_cnt++;
      if (rsp_vld_o != 0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_vld_o), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_vld", 32'(rsp_vld_o), 32'(1 << e.id));
          chk("rsp_id", 32'(rsp_id_o), 32'(e.id));
          chk("rsp_res", 32'(rsp_res_o), 32'(e.res));
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          chk("sqrt_op", 32'(sqrt_op_o), 32'(e.op));
          chk("enb_cycles", 32'(enb_cnt), 32'(e.enb));
          tb_ptr = (e.id + 1) % N;
          inflight = 0;
        end
      end
      hs = req_vld_i & req_rdy_o;
      if (hs != 0) begin
        g = winner(0, hs);
        if (w < 0) w = g;
        e.id  = w;
        e.op  = pend_op[w][0];
        e.res = stuck ? 0 : isqrt(e.op);
        e.err = stuck ? 1 : 0;
        e.enb = stuck ? TO : 2;
        exp_q.push_back(e);
        pop_req  = g;
        inflight = 1;
        enb_cnt  = 0;
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((inflight != 0 || exp_q.size() != 0 || pend_total() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk("drain", 32'(pend_total() + inflight + exp_q.size()), 32'(0));
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 32'(req_rdy_o), 32'(0));
    chk({tag, "_rsp_vld"}, 32'(rsp_vld_o), 32'(0));
    chk({tag, "_rsp_res"}, 32'(rsp_res_o), 32'(0));
    chk({tag, "_rsp_err"}, 32'(rsp_err_o), 32'(0));
    chk({tag, "_rsp_id"}, 32'(rsp_id_o), 32'(0));
    chk({tag, "_enb"}, 32'(sqrt_enb_o), 32'(0));
    chk({tag, "_op"}, 32'(sqrt_op_o), 32'(0));
    chk({tag, "_busy"}, 32'(busy_o), 32'(0));
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) pend_n[k] = 0;
    pop_req = -1;
    exp_q.delete();
    inflight = 0;
    tb_ptr = 0;
    enb_cnt = 0;
    repeat (n) tick();
    check_zero(tag);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    do_reset(3, "reset");

    // Single request with a perfect square.
    push(1, 144);
    drain(50);

    // All requesters at once; requester 0 queues a second operand.
    do_reset(2, "reset2");
    push(0, 0); push(0, 49); push(1, 1); push(2, 255); push(3, 100);
    drain(120);

    // Pointer wrap and skip over idle requesters.
    push(2, 36);
    drain(50);
    push(1, 64);
    drain(50);
    push(1, 4); push(3, 9); push(2, 121);
    drain(100);

    // Unit never responds: watchdog abort, then a normal transaction.
    stuck = 1'b1;
    push(0, 9);
    drain(50);
    stuck = 1'b0;
    push(3, 16);
    drain(50);

    // Reset while the unit is mid-computation; unit stays busy afterwards.
    m_lat = 6;
    push(2, 81);
    n = 0;
    while (!(busy_o && !sqrt_enb_o && sqrt_busy_i) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_run", 32'(busy_o && !sqrt_enb_o && sqrt_busy_i), 32'(1));
    m_lat = 2;
    n_busy_wait = 0;
    do_reset(1, "mid_reset");
    push(0, 25);
    drain(60);
    chk("busy_hold", 32'(n_busy_wait >= 3), 32'(1));

    // Completion lands on the same cycle the watchdog would fire.
    m_lat = 5;
    push(1, 200);
    drain(50);
    m_lat = 2;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one sqrt_fsm datapath instance (sqrt_ctrl plus its processor) between N_REQ requesters.
- Round-robin arbitration; accepts one operand at a time and launches the unit with an enable pulse.
- Detects completion from the unit's busy signal and returns the result to the granted requester.
- Includes a watchdog that aborts a hung transaction and reports an error response.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OP_W, 8, operand width of the sqrt unit.
- RES_W, 4, result width; must be >= ceil(OP_W/2).
- TIMEOUT, 255, maximum cycles in LAUNCH+RUN before abort (>= 2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_vld_i  input  N_REQ  per-requester request valid.
- req_op_i  input  N_REQ*OP_W  operands; requester k at bits [k*OP_W +: OP_W].
- req_rdy_o  output  N_REQ  accept strobe; handshake completes when vld&rdy are both high.
- rsp_vld_o  output  N_REQ  one-cycle response pulse to the owning requester.
- rsp_res_o  output  RES_W  shared result bus; valid while any rsp_vld_o bit is high.
- rsp_err_o  output  1  high with rsp_vld_o when the transaction timed out.
- rsp_id_o  output  clog2(N_REQ)  index of the responding requester.
- sqrt_enb_o  output  1  to the sqrt unit's enb_i.
- sqrt_op_o  output  OP_W  operand to the sqrt unit; held stable from launch until response.
- sqrt_busy_i  input  1  from the sqrt unit's busy_o.
- sqrt_res_i  input  RES_W  sqrt unit result; valid in the cycle busy falls.
- busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to IDLE; round-robin pointer ptr=0; watchdog cnt=0.
  - All outputs go to 0.
  - Reset mid-transaction drops the transaction with no response.
- FSM states: IDLE, LAUNCH, RUN, RESP.
- IDLE:
  - Grant only if some req_vld_i is high AND sqrt_busy_i=0.
  - Winner g is the first set bit searching ptr, ptr+1, ... modulo N_REQ.
  - req_rdy_o[g]=1 combinationally in the same cycle; no other rdy bit is high.
  - At the edge: latch sqrt_op_o <= operand g, id <= g, cnt <= 0; go to LAUNCH.
  - If sqrt_busy_i=1 (e.g. the unit is still running after an arbiter reset), stay in IDLE with all rdy low.
- LAUNCH:
  - sqrt_enb_o=1 (registered, high for the whole state); cnt increments each cycle.
  - sqrt_busy_i=1 sampled: go to RUN; sqrt_enb_o drops at that edge.
- RUN:
  - sqrt_enb_o=0; cnt increments each cycle.
  - sqrt_busy_i=0 sampled: capture res <= sqrt_res_i, err <= 0; go to RESP.
- Watchdog (LAUNCH or RUN):
  - If cnt reaches TIMEOUT-1 without the exit condition, next state is RESP with err=1 and res=0; sqrt_enb_o deasserts.
  - If completion and timeout occur in the same cycle, completion wins.
- RESP (exactly one cycle):
  - rsp_vld_o[id]=1, rsp_id_o=id, rsp_res_o=res, rsp_err_o=err.
  - ptr <= (id+1) mod N_REQ; go to IDLE.
  - rsp_res_o, rsp_err_o and rsp_id_o hold their last values afterwards; they are valid only when qualified by rsp_vld_o.
- Pointer and fairness:
  - ptr advances on both successful and error responses.
  - A requester dropping req_vld_i before its grant is legal; it is not remembered.
  - Requests arriving during LAUNCH/RUN/RESP wait; the earliest re-grant is the cycle after RESP.
  - Fairness: with all N_REQ requesting continuously, grants rotate 0,1,...,N_REQ-1,0.
- Throughput: at most one transaction in flight.
- Minimum turnaround: handshake cycle + LAUNCH (>=1) + RUN (>=1) + RESP, i.e. 4 cycles plus unit latency.
- Operand handling:
  - sqrt_op_o is registered and changes only at a grant edge.
  - Operands are passed unmodified; no width conversion.

Test Plan:
- Single request, ideal unit: req 1 with op=8'd144 against the real sqrt_fsm → rdy[1] pulses once; one rsp_vld_o[1] pulse with res=12, err=0, id=1; busy_o low afterwards.
- Round-robin: all 4 requesters hold vld with ops 0, 1, 255, 100 → responses in id order 0,1,2,3,0 with res 0, 1, 15, 10; exactly one rdy bit per grant.
- Pointer wrap/skip: ptr=3 after serving id 2, only req 1 valid → grant 1; next ptr=2.
- Timeout: unit model never raises busy, TIMEOUT=8 → sqrt_enb_o high for 8 cycles, then rsp_vld_o[id]=1 with err=1, res=0; next request is served normally.
- Busy-at-idle plus reset: assert rst_i mid-RUN while the unit stays busy 5 more cycles → all outputs 0, no response; rdy stays low until sqrt_busy_i=0, then grant proceeds.
- Completion/timeout collision: busy falls in the same cycle cnt hits TIMEOUT-1 → err=0, the captured result is returned.
